wb_stage_nway: RTL and testbench

WB_STAGE_NWAY -- requirements
Module: wb_stage_nway

---
 rtl/wb_stage_nway_pkg.sv | 27 ++
 rtl/wb_stage_nway_lane_pick.sv | 29 ++
 rtl/wb_stage_nway.sv | 107 ++++++++++
 tb/tb_wb_stage_nway.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_nway_pkg.sv
// Shared widths and helpers for the multi-lane writeback stage.
package wb_stage_nway_pkg;

   localparam int unsigned LANES_DEF  = 2;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned PC_W_DEF   = 32;
   localparam int unsigned CNT_W      = 32;
   localparam int unsigned DBG_WEN_W  = 4;

   // One lane is {we, dest, result, pc}, MSB first.
   function automatic int unsigned lane_w(input int unsigned addr_w,
                                          input int unsigned data_w,
                                          input int unsigned pc_w);
      return 1 + addr_w + data_w + pc_w;
   endfunction

   function automatic int unsigned ws_to_rf_bus_wd(input int unsigned addr_w,
                                                   input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/wb_stage_nway_lane_pick.sv
// Finds the next set mask bit above ptr (or the lowest set bit when from_start).
module wb_lane_pick
   import wb_stage_nway_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned PTR_W = 1
) (
   input  logic [LANES-1:0] mask,
   input  logic [PTR_W-1:0] ptr,
   input  logic             from_start,
   output logic [PTR_W-1:0] next_ptr_c,
   output logic             is_last_c
);

   logic found_c;

   always_comb begin
      next_ptr_c = ptr;
      found_c    = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (!found_c && mask[i] && (from_start || (PTR_W'(i) > ptr))) begin
            next_ptr_c = PTR_W'(i);
            found_c    = 1'b1;
         end
      end
      is_last_c = !found_c;
   end

endmodule

// File: rtl/wb_stage_nway.sv
// Writeback stage: accepts an N-lane bundle and commits its valid lanes serially, one per cycle.
module wb_stage_nway
   import wb_stage_nway_pkg::*;
#(
   parameter int unsigned LANES  = LANES_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF
) (
   input  logic                                              clk,
   input  logic                                              reset,
   output logic                                              ws_allowin,
   input  logic                                              ms_to_ws_valid,
   input  logic [LANES-1:0]                                  ms_to_ws_mask,
   input  logic [LANES*lane_w(ADDR_W, DATA_W, PC_W)-1:0]     ms_to_ws_bus,
   output logic [ws_to_rf_bus_wd(ADDR_W, DATA_W)-1:0]        ws_to_rf_bus,
   output logic [PC_W-1:0]                                   debug_wb_pc,
   output logic [DBG_WEN_W-1:0]                              debug_wb_rf_wen,
   output logic [ADDR_W-1:0]                                 debug_wb_rf_wnum,
   output logic [DATA_W-1:0]                                 debug_wb_rf_wdata,
   output logic [CNT_W-1:0]                                  ws_commit_cnt
);

   localparam int unsigned LANE_W = lane_w(ADDR_W, DATA_W, PC_W);
   localparam int unsigned PTR_W  = ptr_w(LANES);

   logic                      ws_valid;
   logic [PTR_W-1:0]          ptr;
   logic [LANES-1:0]          mask_r;
   logic [LANES*LANE_W-1:0]   bundle_r;
   logic [CNT_W-1:0]          commit_cnt;

   logic [PTR_W-1:0]          next_ptr_c;
   logic [PTR_W-1:0]          first_ptr_c;
   logic                      is_last_c;
   logic                      first_unused_c;
   logic [LANE_W-1:0]         lane_c;
   logic                      lane_we_c;
   logic [ADDR_W-1:0]         lane_dest_c;
   logic [DATA_W-1:0]         lane_result_c;
   logic [PC_W-1:0]           lane_pc_c;
   logic                      active_c;
   logic                      lane_live_c;
   logic                      rf_we_c;

   wb_lane_pick #(.LANES(LANES), .PTR_W(PTR_W)) u_step (
      .mask       (mask_r),
      .ptr        (ptr),
      .from_start (1'b0),
      .next_ptr_c (next_ptr_c),
      .is_last_c  (is_last_c)
   );

   wb_lane_pick #(.LANES(LANES), .PTR_W(PTR_W)) u_first (
      .mask       (ms_to_ws_mask),
      .ptr        ({PTR_W{1'b0}}),
      .from_start (1'b1),
      .next_ptr_c (first_ptr_c),
      .is_last_c  (first_unused_c)
   );

   // Unpack the lane under the commit pointer.
   assign lane_c        = bundle_r[int'(ptr)*int'(LANE_W) +: LANE_W];
   assign lane_we_c     = lane_c[LANE_W-1];
   assign lane_dest_c   = lane_c[LANE_W-2 -: ADDR_W];
   assign lane_result_c = lane_c[PC_W +: DATA_W];
   assign lane_pc_c     = lane_c[PC_W-1:0];

   // Reset suppresses any write in the cycle it is asserted.
   assign active_c    = ws_valid && !reset;
   assign lane_live_c = active_c && mask_r[ptr];
   assign rf_we_c     = lane_live_c && lane_we_c;

   assign ws_allowin        = !ws_valid || is_last_c;
   assign ws_to_rf_bus      = {rf_we_c, lane_dest_c, lane_result_c};
   assign debug_wb_rf_wen   = {DBG_WEN_W{rf_we_c}};
   assign debug_wb_pc       = active_c ? lane_pc_c : {PC_W{1'b0}};
   assign debug_wb_rf_wnum  = active_c ? lane_dest_c : {ADDR_W{1'b0}};
   assign debug_wb_rf_wdata = active_c ? lane_result_c : {DATA_W{1'b0}};
   assign ws_commit_cnt     = commit_cnt;

   // Stage state: capture on handshake, otherwise step to the next set lane.
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid   <= 1'b0;
         ptr        <= {PTR_W{1'b0}};
         mask_r     <= {LANES{1'b0}};
         bundle_r   <= {(LANES*LANE_W){1'b0}};
         commit_cnt <= {CNT_W{1'b0}};
      end else begin
         if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
         end
         if (ms_to_ws_valid && ws_allowin) begin
            mask_r   <= ms_to_ws_mask;
            bundle_r <= ms_to_ws_bus;
            ptr      <= first_ptr_c;
         end else if (ws_valid) begin
            ptr <= next_ptr_c;
         end
         if (lane_live_c) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_nway.sv
// Self-checking bench for wb_stage_nway (LANES=2): directed table, hand sequences, random vs queue model.
module tb_wb_stage_nway;

   localparam int unsigned LANES  = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned LANE_W = 1 + ADDR_W + DATA_W + PC_W;
   localparam int unsigned RF_W   = 1 + ADDR_W + DATA_W;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      ws_allowin;
   logic                      ms_to_ws_valid;
   logic [LANES-1:0]          ms_to_ws_mask;
   logic [LANES*LANE_W-1:0]   ms_to_ws_bus;
   logic [RF_W-1:0]           ws_to_rf_bus;
   logic [PC_W-1:0]           debug_wb_pc;
   logic [3:0]                debug_wb_rf_wen;
   logic [ADDR_W-1:0]         debug_wb_rf_wnum;
   logic [DATA_W-1:0]         debug_wb_rf_wdata;
   logic [31:0]               ws_commit_cnt;

   wb_stage_nway #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_mask     (ms_to_ws_mask),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .ws_commit_cnt     (ws_commit_cnt)
   );

   always #5 clk = ~clk;

   wire              rf_we    = ws_to_rf_bus[RF_W-1];
   wire [ADDR_W-1:0] rf_waddr = ws_to_rf_bus[DATA_W +: ADDR_W];
   wire [DATA_W-1:0] rf_wdata = ws_to_rf_bus[DATA_W-1:0];

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_cnt = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [LANE_W-1:0] mk_lane(input logic we, input logic [4:0] dest,
                                                 input logic [31:0] res, input logic [31:0] pc);
      return {we, dest, res, pc};
   endfunction

   typedef struct {
      logic [1:0]          mask;
      logic [2*LANE_W-1:0] bus;
      int                  ncyc;
      logic [1:0]          we;
      logic [9:0]          addr;
      logic [63:0]         data;
      logic [63:0]         pc;
      logic [1:0]          allow;
      int                  dcnt;
   } vec_t;

   typedef struct {
      logic        has;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   vec_t vecs[6];
   ent_t q[$];

   initial begin
      logic [LANE_W-1:0] l0, l1;
      logic acc;
      int b;

      vecs[0] = '{2'b11, {mk_lane(1, 4, 32'h22, 32'h1c000004), mk_lane(1, 3, 32'h11, 32'h1c000000)},
                  2, 2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, {32'h1c000004, 32'h1c000000}, 2'b10, 2};
      vecs[1] = '{2'b10, vecs[0].bus, 1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h22},
                  {32'h0, 32'h1c000004}, 2'b01, 1};
      vecs[2] = '{2'b00, vecs[0].bus, 1, 2'b00, 10'd0, 64'd0, 64'd0, 2'b01, 0};
      vecs[3] = '{2'b11, {mk_lane(1, 5, 32'hB, 32'h1c000104), mk_lane(1, 5, 32'hA, 32'h1c000100)},
                  2, 2'b11, {5'd5, 5'd5}, {32'hB, 32'hA}, {32'h1c000104, 32'h1c000100}, 2'b10, 2};
      vecs[4] = '{2'b11, {mk_lane(1, 7, 32'h77, 32'h1c000204), mk_lane(0, 6, 32'h66, 32'h1c000200)},
                  2, 2'b10, {5'd7, 5'd6}, {32'h77, 32'h66}, {32'h1c000204, 32'h1c000200}, 2'b10, 2};
      vecs[5] = '{2'b01, vecs[0].bus, 1, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h11},
                  {32'h0, 32'h1c000000}, 2'b01, 1};

      // Reset values
      reset = 1'b1;
      ms_to_ws_valid = 1'b0;
      ms_to_ws_mask = '0;
      ms_to_ws_bus = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_allowin", 32'(ws_allowin), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
      chk("rst_dbg_pc", debug_wb_pc, 32'd0);
      chk("rst_dbg_wnum", 32'(debug_wb_rf_wnum), 32'd0);
      chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'd0);
      chk("rst_cnt", ws_commit_cnt, 32'd0);

      // Directed single-bundle table
      foreach (vecs[v]) begin
         @(posedge clk);
         #1;
         ms_to_ws_valid = 1'b1;
         ms_to_ws_mask = vecs[v].mask;
         ms_to_ws_bus = vecs[v].bus;
         @(negedge clk);
         chk($sformatf("v%0d_idle_allowin", v), 32'(ws_allowin), 32'd1);
         @(posedge clk);
         #1 ms_to_ws_valid = 1'b0;
         for (int c = 0; c < vecs[v].ncyc; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_allowin", v, c), 32'(ws_allowin), 32'(vecs[v].allow[c]));
            chk($sformatf("v%0d_c%0d_rf_we", v, c), 32'(rf_we), 32'(vecs[v].we[c]));
            chk($sformatf("v%0d_c%0d_dbg_wen", v, c), 32'(debug_wb_rf_wen), {28'd0, {4{vecs[v].we[c]}}});
            if (vecs[v].we[c]) begin
               chk($sformatf("v%0d_c%0d_waddr", v, c), 32'(rf_waddr), 32'(vecs[v].addr[c*5 +: 5]));
               chk($sformatf("v%0d_c%0d_wdata", v, c), rf_wdata, vecs[v].data[c*32 +: 32]);
            end
            if (vecs[v].mask != 2'b00)
               chk($sformatf("v%0d_c%0d_pc", v, c), debug_wb_pc, vecs[v].pc[c*32 +: 32]);
            if (c < vecs[v].ncyc - 1) @(posedge clk);
         end
         exp_cnt = exp_cnt + 32'(vecs[v].dcnt);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk($sformatf("v%0d_done_rf_we", v), 32'(rf_we), 32'd0);
         chk($sformatf("v%0d_done_allowin", v), 32'(ws_allowin), 32'd1);
         chk($sformatf("v%0d_cnt", v), ws_commit_cnt, exp_cnt);
      end

      // Back-to-back: 8 full bundles, 16 commits with no bubble
      b = 0;
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b1;
      ms_to_ws_mask = 2'b11;
      ms_to_ws_bus = {mk_lane(1, 5'd2, 32'h101, 32'h1c001004), mk_lane(1, 5'd1, 32'h100, 32'h1c001000)};
      for (int cyc = 0; cyc <= 16; cyc++) begin
         @(negedge clk);
         if (cyc > 0) begin
            chk($sformatf("b2b_%0d_rf_we", cyc - 1), 32'(rf_we), 32'd1);
            chk($sformatf("b2b_%0d_pc", cyc - 1), debug_wb_pc, 32'h1c001000 + 32'(4 * (cyc - 1)));
            chk($sformatf("b2b_%0d_waddr", cyc - 1), 32'(rf_waddr), 32'(cyc));
         end
         acc = ws_allowin;
         @(posedge clk);
         #1;
         if (acc) begin
            b++;
            if (b < 8) begin
               l0 = mk_lane(1, 5'(2 * b + 1), 32'h100 + 32'(2 * b), 32'h1c001000 + 32'(8 * b));
               l1 = mk_lane(1, 5'(2 * b + 2), 32'h101 + 32'(2 * b), 32'h1c001004 + 32'(8 * b));
               ms_to_ws_bus = {l1, l0};
            end else begin
               ms_to_ws_valid = 1'b0;
            end
         end
      end
      exp_cnt = exp_cnt + 32'd16;
      @(negedge clk);
      chk("b2b_cnt", ws_commit_cnt, exp_cnt);
      chk("b2b_idle_rf_we", 32'(rf_we), 32'd0);

      // Reset after lane0 commits: lane1 must never be written
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b1;
      ms_to_ws_mask = 2'b11;
      ms_to_ws_bus = {mk_lane(1, 5'd9, 32'h99, 32'h1c002004), mk_lane(1, 5'd8, 32'h88, 32'h1c002000)};
      @(posedge clk);
      #1 ms_to_ws_valid = 1'b0;
      @(negedge clk);
      chk("rmid_lane0_rf_we", 32'(rf_we), 32'd1);
      chk("rmid_lane0_waddr", 32'(rf_waddr), 32'd8);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rmid_rstcyc_rf_we", 32'(rf_we), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_cnt = 32'd0;
      @(negedge clk);
      chk("rmid_after_rf_we", 32'(rf_we), 32'd0);
      chk("rmid_after_allowin", 32'(ws_allowin), 32'd1);
      chk("rmid_after_cnt", ws_commit_cnt, exp_cnt);
      @(negedge clk);
      chk("rmid_later_rf_we", 32'(rf_we), 32'd0);

      // Random traffic against a queue-of-commits model
      q.delete();
      for (int t = 0; t < 300; t++) begin
         logic exp_allow;
         ent_t e;
         @(posedge clk);
         #1;
         ms_to_ws_valid = ($urandom_range(0, 3) != 0);
         ms_to_ws_mask = 2'($urandom);
         for (int l = 0; l < 2; l++)
            ms_to_ws_bus[l*LANE_W +: LANE_W] = mk_lane(1'($urandom), 5'($urandom), $urandom, $urandom);
         @(negedge clk);
         exp_allow = (q.size() <= 1);
         chk($sformatf("rnd%0d_allowin", t), 32'(ws_allowin), 32'(exp_allow));
         if (q.size() > 0) begin
            e = q[0];
            chk($sformatf("rnd%0d_rf_we", t), 32'(rf_we), 32'(e.has && e.we));
            if (e.has && e.we) begin
               chk($sformatf("rnd%0d_waddr", t), 32'(rf_waddr), 32'(e.dest));
               chk($sformatf("rnd%0d_wdata", t), rf_wdata, e.data);
            end
            if (e.has) chk($sformatf("rnd%0d_pc", t), debug_wb_pc, e.pc);
            if (e.has) exp_cnt = exp_cnt + 32'd1;
            void'(q.pop_front());
         end else begin
            chk($sformatf("rnd%0d_idle_rf_we", t), 32'(rf_we), 32'd0);
         end
         chk($sformatf("rnd%0d_cnt", t), ws_commit_cnt, exp_cnt - ((q.size() >= 0 && e.has) ? 32'd0 : 32'd0)
             - ((exp_cnt != 32'd0 && e.has) ? 32'd1 : 32'd0));
         if (exp_allow && ms_to_ws_valid) begin
            if (ms_to_ws_mask == 2'b00) begin
               q.push_back('{1'b0, 1'b0, 5'd0, 32'd0, 32'd0});
            end else begin
               for (int l = 0; l < 2; l++) begin
                  if (ms_to_ws_mask[l]) begin
                     l0 = ms_to_ws_bus[l*LANE_W +: LANE_W];
                     q.push_back('{1'b1, l0[LANE_W-1], l0[LANE_W-2 -: 5], l0[PC_W +: DATA_W], l0[PC_W-1:0]});
                  end
               end
            end
         end
         e = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
